smart_energy_meter_mc: RTL and testbench
========================================

Name: smart_energy_meter_mc

Overview:
Multi-channel successor to the single-load energy meter. Accumulates energy per channel from load_on pulses and computes a two-slab tariff bill per channel. Raises per-channel alert levels. Serialises alert events to the GSM modem through a valid/ready message port, using round-robin arbitration and an inter-message cooldown.

Parameters:
N_CH, 4, number of metered channels (1..8)
ENERGY_W, 16, energy_units width per channel
BILL_W, 24, bill_amount width per channel
PULSES_PER_UNIT, 10, load_on-high cycles per energy unit (>=2)
SLAB_UNITS, 25, last unit billed at RATE1
RATE1, 5, bill increment per unit up to and including SLAB_UNITS
RATE2, 8, bill increment per unit above SLAB_UNITS
WARN_UNITS, 20, energy at which alert level becomes 1
LIMIT_UNITS, 30, energy at which alert level becomes 2 (>=WARN_UNITS)
COOLDOWN, 4, idle cycles enforced after each accepted message

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
load_on  in  N_CH  per-channel load active
clear  in  N_CH  per-channel synchronous clear (billing cycle rollover)
energy_units  out  N_CH*ENERGY_W  channel i at [i*ENERGY_W +: ENERGY_W]
bill_amount  out  N_CH*BILL_W  channel i at [i*BILL_W +: BILL_W]
alert_level  out  2*N_CH  channel i at [2i +: 2]; 0 normal, 1 warn, 2 limit
gsm_valid  out  1  message available
gsm_ready  in  1  modem accepts message
gsm_ch  out  3  channel index of message
gsm_level  out  2  alert level carried by message
gsm_units  out  ENERGY_W  energy snapshot carried by message

Behaviour:
- Reset (reset_n low, async): all counters, energy, bill, alert, pending flags, and gsm_* outputs are 0. FSM goes to IDLE.
- Pulse counter per channel: increments on each cycle with load_on[i]=1. At PULSES_PER_UNIT-1 it wraps to 0 and energy increments on the same edge.
- Energy saturates at 2^ENERGY_W-1. At saturation the pulse counter keeps wrapping; energy and bill hold.
- Bill increments on the same edge as energy. Increment is RATE1 if the new unit value <= SLAB_UNITS, else RATE2. Bill saturates at 2^BILL_W-1.
- Alert: one cycle after energy changes, level = 2 if energy>=LIMIT_UNITS, 1 if >=WARN_UNITS, else 0. Level never decreases except via clear or reset.
- Event on any level increase sets pending[i] on the same edge the level updates.
  - Crossing both thresholds at once (WARN_UNITS==LIMIT_UNITS) produces one event at level 2.
  - An event on a channel whose pending[i] is already set leaves it set (no queueing).
- clear[i] zeroes pulse counter, energy, bill, alert, and pending for channel i next edge. It overrides a simultaneous unit increment or event. Other channels are unaffected.
- GSM FSM:
  - IDLE: if any pending, grant the lowest index >= rr_ptr (wrapping). Latch gsm_ch, gsm_level (current level), and gsm_units (current energy). Clear that pending bit. Go to SEND; gsm_valid=1 from the next cycle.
  - SEND: gsm_valid stays high and payload stays stable until gsm_valid&&gsm_ready. On handshake: gsm_valid=0, rr_ptr=granted+1 mod N_CH, go to HOLD.
  - HOLD: wait COOLDOWN cycles, then IDLE. No grant occurs during HOLD.
  - clear of the granted channel during SEND does not abort the message; the latched payload is sent.
  - An event on the granted channel during SEND re-sets its pending bit, giving a second message later.
- Latency: unit edge k -> alert/pending edge k+1 -> grant edge k+2 -> gsm_valid high after edge k+2 (when IDLE).
- gsm_ready while gsm_valid=0 is ignored.

Test Plan:
- Reset then load_on[0]=1 for 10 cycles -> energy ch0=1, bill=5; other channels 0. load_on=0 holds values.
- Ch0 load held 250 cycles -> energy=25, bill=125. 50 more cycles -> energy=30, bill=165, alert=2. Two GSM messages in order: (ch0, lvl1, units20), then (ch0, lvl2, units30).
- Ch1 and ch3 cross WARN in the same cycle, gsm_ready=1 -> messages ch1 then ch3. gsm_valid low for exactly COOLDOWN=4 cycles between them. rr_ptr afterwards is 0.
- gsm_ready=0 for 20 cycles during SEND -> gsm_valid and payload stable throughout. A ready pulse gives exactly one handshake.
- clear[2] asserted on the same edge a ch2 unit increment would occur -> energy, bill, and alert for ch2 become 0. No event is raised.
- reset_n pulsed low mid-SEND, asynchronously between clock edges -> gsm_valid, energy, bill, and alert drop to 0 immediately. FSM returns to IDLE.

Source files
------------

// File: rtl/smart_energy_meter_mc.sv
// smart_energy_meter_mc
// Multi-channel energy meter. Each channel counts load_on-high cycles into
// energy units, accumulates a two-slab tariff bill, and tracks a monotonic
// alert level. Alert-level increases raise a per-channel pending flag; a
// round-robin GSM FSM turns pending flags into messages on a valid/ready port
// and enforces a cooldown gap between messages.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   load_on[N_CH]         per-channel load active (one pulse per high cycle)
//   clear[N_CH]           per-channel synchronous clear (billing rollover)
//   energy_units          channel i at [i*ENERGY_W +: ENERGY_W]
//   bill_amount           channel i at [i*BILL_W +: BILL_W]
//   alert_level           channel i at [2i +: 2]; 0 normal, 1 warn, 2 limit
//   gsm_valid/gsm_ready   message handshake
//   gsm_ch/level/units    message payload (channel, level, energy snapshot)
//   dbg_state_o           GSM FSM state (0 idle, 1 send, 2 hold)
//   dbg_rr_ptr_o          round-robin start channel for the next grant
//
// Handshake: gsm_valid is raised with a stable payload and held until a
// cycle where gsm_valid && gsm_ready at the rising edge; that edge transfers
// the message and drops gsm_valid. gsm_ready while gsm_valid is low is ignored.
module smart_energy_meter_mc #(
    parameter int N_CH            = 4,
    parameter int ENERGY_W        = 16,
    parameter int BILL_W          = 24,
    parameter int PULSES_PER_UNIT = 10,
    parameter int SLAB_UNITS      = 25,
    parameter int RATE1           = 5,
    parameter int RATE2           = 8,
    parameter int WARN_UNITS      = 20,
    parameter int LIMIT_UNITS     = 30,
    parameter int COOLDOWN        = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_CH-1:0]            load_on,
    input  logic [N_CH-1:0]            clear,
    output logic [N_CH*ENERGY_W-1:0]   energy_units,
    output logic [N_CH*BILL_W-1:0]     bill_amount,
    output logic [2*N_CH-1:0]          alert_level,
    output logic                       gsm_valid,
    input  logic                       gsm_ready,
    output logic [2:0]                 gsm_ch,
    output logic [1:0]                 gsm_level,
    output logic [ENERGY_W-1:0]        gsm_units,
    output logic [1:0]                 dbg_state_o,
    output logic [2:0]                 dbg_rr_ptr_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int PW = $clog2(PULSES_PER_UNIT);
    localparam logic [PW-1:0]       PULSE_LAST = PW'(PULSES_PER_UNIT - 1);
    localparam logic [ENERGY_W-1:0] E_MAX      = '1;
    localparam logic [BILL_W-1:0]   B_MAX      = '1;
    localparam logic [ENERGY_W-1:0] SLAB_E     = ENERGY_W'(SLAB_UNITS);
    localparam logic [ENERGY_W-1:0] WARN_E     = ENERGY_W'(WARN_UNITS);
    localparam logic [ENERGY_W-1:0] LIMIT_E    = ENERGY_W'(LIMIT_UNITS);
    localparam logic [BILL_W:0]     RATE1_B    = (BILL_W+1)'(RATE1);
    localparam logic [BILL_W:0]     RATE2_B    = (BILL_W+1)'(RATE2);

    // The handshake edge already contributes one low cycle of gsm_valid and
    // the IDLE grant edge another, so HOLD lasts COOLDOWN-1 cycles and
    // gsm_valid is low for exactly COOLDOWN cycles between messages.
    localparam int CW = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'((COOLDOWN >= 2) ? (COOLDOWN - 2) : 0);

    state_e              state_q;
    logic [2:0]          rr_ptr_q;
    logic [CW-1:0]       hold_cnt_q;

    logic [N_CH-1:0]     pending_w;
    logic                grant_found;
    logic [2:0]          grant_idx;
    logic                grant_fire;
    logic [1:0]          sel_level;
    logic [ENERGY_W-1:0] sel_units;

    assign grant_fire   = (state_q == ST_IDLE) && grant_found;
    assign dbg_state_o  = state_q;
    assign dbg_rr_ptr_o = rr_ptr_q;

    // ------------------------------------------------------------------
    // Per-channel metering
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [PW-1:0]       pulse_q,   pulse_d;
        logic [ENERGY_W-1:0] energy_q,  energy_d;
        logic [BILL_W-1:0]   bill_q,    bill_d;
        logic [1:0]          alert_q,   alert_d;
        logic                pending_q, pending_d;
        logic                unit_tick;
        logic [BILL_W:0]     bill_sum;
        logic [1:0]          lvl_now;

        always_comb begin
            pulse_d   = pulse_q;
            energy_d  = energy_q;
            bill_d    = bill_q;
            alert_d   = alert_q;
            pending_d = pending_q;
            unit_tick = 1'b0;
            bill_sum  = '0;
            lvl_now   = 2'd0;

            if (load_on[i]) begin
                if (pulse_q == PULSE_LAST) begin
                    pulse_d   = '0;
                    unit_tick = 1'b1;
                end else begin
                    pulse_d = pulse_q + 1'b1;
                end
            end

            // New unit value energy_q+1 is within the first slab iff
            // energy_q < SLAB_UNITS.
            if (unit_tick && (energy_q != E_MAX)) begin
                energy_d = energy_q + 1'b1;
                bill_sum = {1'b0, bill_q} + ((energy_q < SLAB_E) ? RATE1_B : RATE2_B);
                bill_d   = bill_sum[BILL_W] ? B_MAX : bill_sum[BILL_W-1:0];
            end

            // Level follows the registered energy, so it lags energy by one edge.
            if (energy_q >= LIMIT_E) begin
                lvl_now = 2'd2;
            end else if (energy_q >= WARN_E) begin
                lvl_now = 2'd1;
            end

            if (grant_fire && (grant_idx == 3'(i))) begin
                pending_d = 1'b0;
            end
            // An event re-arms pending even on the edge it is being granted.
            if (lvl_now > alert_q) begin
                alert_d   = lvl_now;
                pending_d = 1'b1;
            end

            if (clear[i]) begin
                pulse_d   = '0;
                energy_d  = '0;
                bill_d    = '0;
                alert_d   = 2'd0;
                pending_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                pulse_q   <= '0;
                energy_q  <= '0;
                bill_q    <= '0;
                alert_q   <= 2'd0;
                pending_q <= 1'b0;
            end else begin
                pulse_q   <= pulse_d;
                energy_q  <= energy_d;
                bill_q    <= bill_d;
                alert_q   <= alert_d;
                pending_q <= pending_d;
            end
        end

        assign energy_units[i*ENERGY_W +: ENERGY_W] = energy_q;
        assign bill_amount[i*BILL_W +: BILL_W]      = bill_q;
        assign alert_level[2*i +: 2]                = alert_q;
        assign pending_w[i]                         = pending_q;
    end

    // ------------------------------------------------------------------
    // Round-robin arbitration: lowest pending index >= rr_ptr, else the
    // lowest pending index overall (wrap-around).
    // ------------------------------------------------------------------
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 3'd0;
        for (int k = 0; k < N_CH; k++) begin
            if (!grant_found && pending_w[k] && (3'(k) >= rr_ptr_q)) begin
                grant_found = 1'b1;
                grant_idx   = 3'(k);
            end
        end
        for (int k = 0; k < N_CH; k++) begin
            if (!grant_found && pending_w[k]) begin
                grant_found = 1'b1;
                grant_idx   = 3'(k);
            end
        end
    end

    always_comb begin
        sel_level = 2'd0;
        sel_units = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (grant_idx == 3'(k)) begin
                sel_level = alert_level[2*k +: 2];
                sel_units = energy_units[k*ENERGY_W +: ENERGY_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // GSM message FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= 3'd0;
            hold_cnt_q <= '0;
            gsm_valid  <= 1'b0;
            gsm_ch     <= 3'd0;
            gsm_level  <= 2'd0;
            gsm_units  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_found) begin
                        gsm_ch    <= grant_idx;
                        gsm_level <= sel_level;
                        gsm_units <= sel_units;
                        gsm_valid <= 1'b1;
                        state_q   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Payload is latched; a clear of this channel does not abort it.
                    if (gsm_ready) begin
                        gsm_valid  <= 1'b0;
                        rr_ptr_q   <= (gsm_ch == 3'(N_CH - 1)) ? 3'd0 : gsm_ch + 3'd1;
                        hold_cnt_q <= '0;
                        state_q    <= (COOLDOWN < 2) ? ST_IDLE : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smart_energy_meter_mc.sv
// Self-checking bench for smart_energy_meter_mc: a cycle-level behavioural
// model predicts energy/bill/alert per channel and the GSM message stream,
// a compare process checks the DUT on every falling edge, and directed
// scenarios pin the model with hand-computed literals.
module tb_smart_energy_meter_mc;

    localparam int N_CH  = 4;
    localparam int EW    = 16;
    localparam int BW    = 24;
    localparam int PPU   = 10;
    localparam int SLAB  = 25;
    localparam int R1    = 5;
    localparam int R2    = 8;
    localparam int WARN  = 20;
    localparam int LIMIT = 30;
    localparam int CD    = 4;
    localparam int MW    = 3 + 2 + EW;
    localparam int EMAX  = (1 << EW) - 1;
    localparam int BMAX  = (1 << BW) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic                  clk       = 1'b0;
    logic                  reset_n   = 1'b0;
    logic [N_CH-1:0]       load_on   = '0;
    logic [N_CH-1:0]       clear     = '0;
    logic                  gsm_ready = 1'b0;
    logic [N_CH*EW-1:0]    energy_units;
    logic [N_CH*BW-1:0]    bill_amount;
    logic [2*N_CH-1:0]     alert_level;
    logic                  gsm_valid;
    logic [2:0]            gsm_ch;
    logic [1:0]            gsm_level;
    logic [EW-1:0]         gsm_units;
    logic [1:0]            dbg_state;
    logic [2:0]            dbg_rr_ptr;

    always #5 clk = ~clk;

    smart_energy_meter_mc dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_on      (load_on),
        .clear        (clear),
        .energy_units (energy_units),
        .bill_amount  (bill_amount),
        .alert_level  (alert_level),
        .gsm_valid    (gsm_valid),
        .gsm_ready    (gsm_ready),
        .gsm_ch       (gsm_ch),
        .gsm_level    (gsm_level),
        .gsm_units    (gsm_units),
        .dbg_state_o  (dbg_state),
        .dbg_rr_ptr_o (dbg_rr_ptr)
    );

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int energy_of(input int cnt);
        int e;
        e = cnt / PPU;
        if (e > EMAX) e = EMAX;
        return e;
    endfunction

    function automatic longint bill_of(input int e);
        longint b;
        if (e <= SLAB) b = longint'(R1) * e;
        else           b = longint'(R1) * SLAB + longint'(R2) * (e - SLAB);
        if (b > BMAX) b = BMAX;
        return b;
    endfunction

    function automatic int lvl_of(input int e);
        if (e >= LIMIT) return 2;
        if (e >= WARN)  return 1;
        return 0;
    endfunction

    int             m_cnt   [N_CH];   // load-high cycles since clear
    int             m_alert [N_CH];
    bit             m_pend  [N_CH];
    bit             m_valid;
    int             m_ch, m_lvl, m_units, m_rr, m_gap;
    logic [MW-1:0]  exp_q[$];
    logic [MW-1:0]  act_q[$];

    int o_cnt   [N_CH];
    int o_alert [N_CH];
    bit o_pend  [N_CH];
    int g, lv;

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_cnt[i] = 0; m_alert[i] = 0; m_pend[i] = 1'b0;
        end
        m_valid = 1'b0; m_ch = 0; m_lvl = 0; m_units = 0; m_rr = 0; m_gap = 0;
        exp_q.delete();
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                model_reset();
            end else begin
                for (int i = 0; i < N_CH; i++) begin
                    o_cnt[i] = m_cnt[i]; o_alert[i] = m_alert[i]; o_pend[i] = m_pend[i];
                end
                g = -1;
                // Messaging: a message stays until ready; after acceptance no new
                // grant for COOLDOWN edges, so valid stays low COOLDOWN cycles.
                if (m_valid) begin
                    if (gsm_ready) begin
                        m_valid = 1'b0;
                        m_rr    = (m_ch + 1) % N_CH;
                        m_gap   = CD;
                    end
                end else if (m_gap > 1) begin
                    m_gap--;
                end else begin
                    for (int k = 0; k < N_CH; k++)
                        if (g < 0 && o_pend[(m_rr + k) % N_CH]) g = (m_rr + k) % N_CH;
                    if (g >= 0) begin
                        m_valid = 1'b1;
                        m_ch    = g;
                        m_lvl   = o_alert[g];
                        m_units = energy_of(o_cnt[g]);
                        exp_q.push_back({3'(m_ch), 2'(m_lvl), EW'(m_units)});
                    end
                end
                for (int i = 0; i < N_CH; i++) begin
                    lv = lvl_of(energy_of(o_cnt[i]));
                    if (load_on[i]) m_cnt[i] = o_cnt[i] + 1;
                    m_pend[i] = o_pend[i] && (g != i);
                    if (lv > o_alert[i]) begin
                        m_alert[i] = lv;
                        m_pend[i]  = 1'b1;
                    end
                    if (clear[i]) begin
                        m_cnt[i] = 0; m_alert[i] = 0; m_pend[i] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- compare process (every falling edge) ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                for (int i = 0; i < N_CH; i++) begin
                    check($sformatf("energy[%0d]", i), 64'(energy_units[i*EW +: EW]), 64'(energy_of(m_cnt[i])));
                    check($sformatf("bill[%0d]", i), 64'(bill_amount[i*BW +: BW]), 64'(bill_of(energy_of(m_cnt[i]))));
                    check($sformatf("alert[%0d]", i), 64'(alert_level[2*i +: 2]), 64'(m_alert[i]));
                end
                check("gsm_valid", 64'(gsm_valid), 64'(m_valid));
                check("rr_ptr", 64'(dbg_rr_ptr), 64'(m_rr));
                if (m_valid) begin
                    check("gsm_ch", 64'(gsm_ch), 64'(m_ch));
                    check("gsm_level", 64'(gsm_level), 64'(m_lvl));
                    check("gsm_units", 64'(gsm_units), 64'(m_units));
                end
            end
        end
    end

    // ---------------- handshake scoreboard and gap monitor ----------------
    int low_run  = 0;
    int last_gap = 0;
    logic [MW-1:0] act_msg;

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && gsm_valid && gsm_ready) begin
                act_msg = {gsm_ch, gsm_level, gsm_units};
                act_q.push_back(act_msg);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL gsm_msg: got %0h expected none", act_msg);
                end else begin
                    check("gsm_msg", 64'(act_msg), 64'(exp_q.pop_front()));
                end
            end
            if (gsm_valid) begin
                if (low_run > 0) last_gap = low_run;
                low_run = 0;
            end else begin
                low_run++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, input string name);
        int t;
        t = 0;
        while (!gsm_valid && t < budget) begin
            tick(1);
            t++;
        end
        check(name, 64'(gsm_valid), 64'd1);
    endtask

    function automatic logic [MW-1:0] msg(input int ch, input int lvl, input int units);
        return {3'(ch), 2'(lvl), EW'(units)};
    endfunction

    int base;

    // ---------------- directed scenarios ----------------
    initial begin
        tick(3);
        check("rst_energy", 64'(energy_units), 64'd0);
        check("rst_bill", 64'(bill_amount), 64'd0);
        check("rst_alert", 64'(alert_level), 64'd0);
        check("rst_valid", 64'(gsm_valid), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        reset_n   = 1'b1;
        gsm_ready = 1'b1;
        cmp_en    = 1'b1;

        // One unit on ch0 after exactly PULSES_PER_UNIT load cycles.
        load_on = 4'b0001;
        tick(10);
        load_on = 4'b0000;
        check("t1_energy0", 64'(energy_units[15:0]), 64'd1);
        check("t1_bill0", 64'(bill_amount[23:0]), 64'd5);
        check("t1_others", 64'(energy_units[63:16]), 64'd0);
        tick(5);
        check("t1_hold", 64'(energy_units[15:0]), 64'd1);

        // Slab boundary and both alert levels on ch0.
        load_on = 4'b0001;
        tick(240);
        check("t2_energy25", 64'(energy_units[15:0]), 64'd25);
        check("t2_bill125", 64'(bill_amount[23:0]), 64'd125);
        tick(50);
        load_on = 4'b0000;
        check("t2_energy30", 64'(energy_units[15:0]), 64'd30);
        check("t2_bill165", 64'(bill_amount[23:0]), 64'd165);
        tick(1);
        check("t2_alert2", 64'(alert_level[1:0]), 64'd2);
        tick(10);
        check("t2_msg_count", 64'(act_q.size()), 64'd2);
        check("t2_msg0", 64'(act_q[0]), 64'(msg(0, 1, 20)));
        check("t2_msg1", 64'(act_q[1]), 64'(msg(0, 2, 30)));
        check("t2_rr", 64'(dbg_rr_ptr), 64'd1);

        // ch1 and ch3 cross WARN together: round-robin order and cooldown gap.
        base    = act_q.size();
        load_on = 4'b1010;
        tick(200);
        load_on = 4'b0000;
        tick(15);
        check("t3_msg_a", 64'(act_q[base]), 64'(msg(1, 1, 20)));
        check("t3_msg_b", 64'(act_q[base+1]), 64'(msg(3, 1, 20)));
        check("t3_gap", 64'(last_gap), 64'd4);
        check("t3_rr", 64'(dbg_rr_ptr), 64'd0);

        // Backpressure: message held stable for 20 cycles, then one ready pulse.
        gsm_ready = 1'b0;
        load_on   = 4'b0010;
        tick(100);
        load_on   = 4'b0000;
        wait_valid(10, "t4_valid_timeout");
        for (int c = 0; c < 20; c++) begin
            check("t4_hold_valid", 64'(gsm_valid), 64'd1);
            check("t4_hold_payload", 64'({gsm_ch, gsm_level, gsm_units}), 64'(msg(1, 2, 30)));
            tick(1);
        end
        base      = act_q.size();
        gsm_ready = 1'b1;
        tick(1);
        gsm_ready = 1'b0;
        tick(3);
        check("t4_one_hs", 64'(act_q.size()), 64'(base + 1));
        check("t4_msg", 64'(act_q[base]), 64'(msg(1, 2, 30)));
        check("t4_valid_low", 64'(gsm_valid), 64'd0);

        // clear[2] on the edge that would take ch2 from 19 to 20 units.
        gsm_ready = 1'b1;
        base      = act_q.size();
        load_on   = 4'b0100;
        tick(199);
        check("t5_energy19", 64'(energy_units[47:32]), 64'd19);
        clear = 4'b0100;
        tick(1);
        clear   = 4'b0000;
        load_on = 4'b0000;
        check("t5_energy0", 64'(energy_units[47:32]), 64'd0);
        check("t5_bill0", 64'(bill_amount[71:48]), 64'd0);
        tick(5);
        check("t5_alert0", 64'(alert_level[5:4]), 64'd0);
        check("t5_no_msg", 64'(act_q.size()), 64'(base));

        // Asynchronous reset in the middle of SEND.
        gsm_ready = 1'b0;
        load_on   = 4'b1000;
        tick(100);
        load_on   = 4'b0000;
        wait_valid(10, "t6_valid_timeout");
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("t6_valid", 64'(gsm_valid), 64'd0);
        check("t6_energy", 64'(energy_units), 64'd0);
        check("t6_bill", 64'(bill_amount), 64'd0);
        check("t6_alert", 64'(alert_level), 64'd0);
        check("t6_state", 64'(dbg_state), 64'd0);
        tick(2);
        reset_n = 1'b1;
        tick(3);
        check("t6_after", 64'(energy_units), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
